// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 definitions used by the write arbiter and its route FIFO.
package axi4_globals_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      AW_PHASE = 2'd1,
      W_PHASE  = 2'd2
   } arb_state_e;

   localparam int OUTSTANDING_DEPTH_DEFAULT = 16;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_LEN_WIDTH  = 8;
   localparam int AXI_QOS_WIDTH  = 4;
   localparam int AXI_RESP_WIDTH = 2;

endpackage

// File: rtl/axi4_route_fifo.sv
// Circular FIFO remembering which requester owns each outstanding write burst.
// A push into a full FIFO or a pop from an empty one is ignored.
module axi4_route_fifo
   import axi4_globals_pkg::*;
#(
   parameter int DEPTH = OUTSTANDING_DEPTH_DEFAULT,
   parameter int WIDTH = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               head,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/axi4_write_arbiter.sv
// N-to-1 AXI4 write arbiter: one burst at a time on AW/W, B routed back by a FIFO.
// Define AXI4_WR_ARB_QOS_EN to arbitrate on highest awqos (round-robin among ties).
module axi4_write_arbiter
   import axi4_globals_pkg::*;
#(
   parameter int NUM_REQ           = 2,
   parameter int ADDRESS_WIDTH     = 32,
   parameter int DATA_WIDTH        = 64,
   parameter int OUTSTANDING_DEPTH = OUTSTANDING_DEPTH_DEFAULT
) (
   input  logic                                    aclk,
   input  logic                                    areset,
   input  logic [NUM_REQ-1:0]                      s_awvalid,
   output logic [NUM_REQ-1:0]                      s_awready,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]        s_awaddr,
   input  logic [NUM_REQ*4-1:0]                    s_awid,
   input  logic [NUM_REQ*8-1:0]                    s_awlen,
   input  logic [NUM_REQ*4-1:0]                    s_awqos,
   input  logic [NUM_REQ-1:0]                      s_wvalid,
   input  logic [NUM_REQ-1:0]                      s_wlast,
   output logic [NUM_REQ-1:0]                      s_wready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]           s_wdata,
   input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]       s_wstrb,
   output logic [NUM_REQ-1:0]                      s_bvalid,
   input  logic [NUM_REQ-1:0]                      s_bready,
   output logic [1:0]                              s_bresp,
   output logic [3:0]                              s_bid,
   output logic                                    m_awvalid,
   input  logic                                    m_awready,
   output logic [ADDRESS_WIDTH-1:0]                m_awaddr,
   output logic [3:0]                              m_awid,
   output logic [7:0]                              m_awlen,
   output logic [3:0]                              m_awqos,
   output logic                                    m_wvalid,
   output logic                                    m_wlast,
   output logic [DATA_WIDTH-1:0]                   m_wdata,
   output logic [DATA_WIDTH/8-1:0]                 m_wstrb,
   input  logic                                    m_wready,
   input  logic                                    m_bvalid,
   output logic                                    m_bready,
   input  logic [1:0]                              m_bresp,
   input  logic [3:0]                              m_bid,
   output logic [$clog2(OUTSTANDING_DEPTH+1)-1:0]  outstanding_cnt,
   output logic                                    orphan_b,
   output logic [1:0]                              arb_state
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int STRB_W = DATA_WIDTH / 8;

   arb_state_e       state_q;
   arb_state_e       state_d;
   logic [IDX_W-1:0] winner_q;
   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] pick;
   logic             pick_valid;
   logic [NUM_REQ-1:0] eligible;
   logic             grant;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic [IDX_W-1:0] head;

`ifdef AXI4_WR_ARB_QOS_EN
   logic [3:0] max_qos;

   always_comb begin
      max_qos = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (s_awvalid[i] && (s_awqos[i*4 +: 4] > max_qos)) max_qos = s_awqos[i*4 +: 4];
      end
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = s_awvalid[i] && (s_awqos[i*4 +: 4] == max_qos);
      end
   end
`else
   assign eligible = s_awvalid;
`endif

   // Round-robin scan begins one past the previous winner.
   always_comb begin
      pick       = last_q;
      pick_valid = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!pick_valid && eligible[(int'(last_q) + i) % NUM_REQ]) begin
            pick       = IDX_W'((int'(last_q) + i) % NUM_REQ);
            pick_valid = 1'b1;
         end
      end
   end

   assign grant     = (state_q == IDLE) && pick_valid && !fifo_full;
   assign push      = m_awvalid && m_awready;
   assign pop       = m_bvalid && m_bready && !fifo_empty;
   assign arb_state = state_q;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q  <= IDLE;
         winner_q <= '0;
         last_q   <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         if (grant) begin
            winner_q <= pick;
            last_q   <= pick;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      m_awvalid = 1'b0;
      s_awready = '0;
      m_wvalid  = 1'b0;
      s_wready  = '0;
      m_awaddr  = s_awaddr[int'(winner_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      m_awid    = s_awid[int'(winner_q)*4 +: 4];
      m_awlen   = s_awlen[int'(winner_q)*8 +: 8];
      m_awqos   = s_awqos[int'(winner_q)*4 +: 4];
      m_wdata   = s_wdata[int'(winner_q)*DATA_WIDTH +: DATA_WIDTH];
      m_wstrb   = s_wstrb[int'(winner_q)*STRB_W +: STRB_W];
      m_wlast   = s_wlast[winner_q];
      case (state_q)
         IDLE: begin
            if (grant) state_d = AW_PHASE;
         end
         // The granted AW is held regardless of the requester's awvalid.
         AW_PHASE: begin
            m_awvalid           = 1'b1;
            s_awready[winner_q] = m_awready;
            if (m_awready) state_d = W_PHASE;
         end
         W_PHASE: begin
            m_wvalid           = s_wvalid[winner_q];
            s_wready[winner_q] = m_wready;
            if (m_wvalid && m_wready && m_wlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // With nothing outstanding a response is accepted and dropped.
   always_comb begin
      s_bvalid = '0;
      m_bready = 1'b0;
      orphan_b = 1'b0;
      s_bresp  = m_bresp;
      s_bid    = m_bid;
      if (!areset) begin
         if (fifo_empty) begin
            m_bready = m_bvalid;
            orphan_b = m_bvalid;
         end else begin
            s_bvalid[head] = m_bvalid;
            m_bready       = s_bready[head];
         end
      end
   end

   axi4_route_fifo #(
      .DEPTH (OUTSTANDING_DEPTH),
      .WIDTH (IDX_W)
   ) u_route_fifo (
      .clk       (aclk),
      .rst       (areset),
      .push      (push),
      .push_data (winner_q),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outstanding_cnt)
   );

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Self-checking bench for axi4_write_arbiter: directed scenarios plus randomized
// bursts compared against a queue-based routing and arbitration model.
module tb_axi4_write_arbiter;

   localparam int NR    = 2;
   localparam int AW    = 32;
   localparam int DW    = 64;
   localparam int SW    = DW / 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int RW    = 2;

   logic              aclk = 1'b0;
   logic              areset = 1'b0;
   logic [NR-1:0]     s_awvalid = '0;
   logic [NR-1:0]     s_awready;
   logic [NR*AW-1:0]  s_awaddr = '0;
   logic [NR*4-1:0]   s_awid = '0;
   logic [NR*8-1:0]   s_awlen = '0;
   logic [NR*4-1:0]   s_awqos = '0;
   logic [NR-1:0]     s_wvalid = '0;
   logic [NR-1:0]     s_wlast = '0;
   logic [NR-1:0]     s_wready;
   logic [NR*DW-1:0]  s_wdata = '0;
   logic [NR*SW-1:0]  s_wstrb = '0;
   logic [NR-1:0]     s_bvalid;
   logic [NR-1:0]     s_bready = '0;
   logic [1:0]        s_bresp;
   logic [3:0]        s_bid;
   logic              m_awvalid;
   logic              m_awready = 1'b0;
   logic [AW-1:0]     m_awaddr;
   logic [3:0]        m_awid;
   logic [7:0]        m_awlen;
   logic [3:0]        m_awqos;
   logic              m_wvalid;
   logic              m_wlast;
   logic [DW-1:0]     m_wdata;
   logic [SW-1:0]     m_wstrb;
   logic              m_wready = 1'b0;
   logic              m_bvalid = 1'b0;
   logic              m_bready;
   logic [1:0]        m_bresp = '0;
   logic [3:0]        m_bid = '0;
   logic [CW-1:0]     outstanding_cnt;
   logic              orphan_b;
   logic [1:0]        arb_state;

   axi4_write_arbiter #(
      .NUM_REQ           (NR),
      .ADDRESS_WIDTH     (AW),
      .DATA_WIDTH        (DW),
      .OUTSTANDING_DEPTH (DEPTH)
   ) dut (
      .aclk            (aclk),
      .areset          (areset),
      .s_awvalid       (s_awvalid),
      .s_awready       (s_awready),
      .s_awaddr        (s_awaddr),
      .s_awid          (s_awid),
      .s_awlen         (s_awlen),
      .s_awqos         (s_awqos),
      .s_wvalid        (s_wvalid),
      .s_wlast         (s_wlast),
      .s_wready        (s_wready),
      .s_wdata         (s_wdata),
      .s_wstrb         (s_wstrb),
      .s_bvalid        (s_bvalid),
      .s_bready        (s_bready),
      .s_bresp         (s_bresp),
      .s_bid           (s_bid),
      .m_awvalid       (m_awvalid),
      .m_awready       (m_awready),
      .m_awaddr        (m_awaddr),
      .m_awid          (m_awid),
      .m_awlen         (m_awlen),
      .m_awqos         (m_awqos),
      .m_wvalid        (m_wvalid),
      .m_wlast         (m_wlast),
      .m_wdata         (m_wdata),
      .m_wstrb         (m_wstrb),
      .m_wready        (m_wready),
      .m_bvalid        (m_bvalid),
      .m_bready        (m_bready),
      .m_bresp         (m_bresp),
      .m_bid           (m_bid),
      .outstanding_cnt (outstanding_cnt),
      .orphan_b        (orphan_b),
      .arb_state       (arb_state)
   );

   always #5 aclk = ~aclk;

   int tests = 0;
   int fails = 0;

   // Model state: owners of outstanding bursts in order, and the previous winner.
   logic [RW-1:0] exp_q[$];
   int            m_last = NR - 1;

   logic [AW-1:0] req_addr [NR];
   logic [3:0]    req_id   [NR];
   logic [7:0]    req_len  [NR];
   logic [3:0]    req_qos  [NR];
   logic [NR-1:0] req_valid = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Winner = first requester after the previous winner among those that are valid
   // (and, with QoS arbitration, carry the highest qos among the valid ones).
   function automatic int model_pick(input logic [NR-1:0] mask);
      int top;
      int idx;
      top = -1;
`ifdef AXI4_WR_ARB_QOS_EN
      for (int i = 0; i < NR; i++) if (mask[i] && int'(req_qos[i]) > top) top = int'(req_qos[i]);
`endif
      for (int off = 1; off <= NR; off++) begin
         idx = (m_last + off) % NR;
         if (mask[idx] && (top < 0 || int'(req_qos[idx]) == top)) return idx;
      end
      return -1;
   endfunction

   task automatic apply_aw();
      for (int i = 0; i < NR; i++) begin
         s_awvalid[i]        = req_valid[i];
         s_awaddr[i*AW +: AW] = req_addr[i];
         s_awid[i*4 +: 4]    = req_id[i];
         s_awlen[i*8 +: 8]   = req_len[i];
         s_awqos[i*4 +: 4]   = req_qos[i];
      end
   endtask

   task automatic drive_w(input int r, input logic [DW-1:0] d, input logic [SW-1:0] st, input logic last);
      for (int i = 0; i < NR; i++) begin
         if (i == r) begin
            s_wvalid[i]          = 1'b1;
            s_wdata[i*DW +: DW]  = d;
            s_wstrb[i*SW +: SW]  = st;
            s_wlast[i]           = last;
         end else begin
            s_wvalid[i]          = 1'($urandom_range(0, 1));
            s_wdata[i*DW +: DW]  = {$urandom, $urandom};
            s_wstrb[i*SW +: SW]  = SW'($urandom);
            s_wlast[i]           = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic clear_w();
      s_wvalid = '0;
      s_wlast  = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m_wready = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_m_awvalid"}, m_awvalid, 0);
      chk({tag, "_s_awready"}, s_awready, 0);
      chk({tag, "_m_wvalid"}, m_wvalid, 0);
      chk({tag, "_s_wready"}, s_wready, 0);
      chk({tag, "_s_bvalid"}, s_bvalid, 0);
      chk({tag, "_m_bready"}, m_bready, 0);
      chk({tag, "_orphan_b"}, orphan_b, 0);
      chk({tag, "_cnt"}, outstanding_cnt, 0);
   endtask

   // Waits for requester r's AW, accepts it, then streams its W beats.
   // wmode 1 toggles m_wready each cycle; abort_beat >= 0 returns mid-burst.
   task automatic serve(input int r, input bit chk_lat, input int wmode, input int abort_beat);
      int n;
      int beats;
      int cyc;
      logic [DW-1:0] d;
      logic [SW-1:0] st;
      logic          last;
      n = 0;
      do begin
         @(posedge aclk); #1;
         n++;
      end while (m_awvalid !== 1'b1 && n < 64);
      chk("aw_grant", m_awvalid, 1);
      if (chk_lat) chk("aw_latency", n, 1);
      chk("aw_addr", m_awaddr, req_addr[r]);
      chk("aw_id", m_awid, req_id[r]);
      chk("aw_len", m_awlen, req_len[r]);
      chk("aw_qos", m_awqos, req_qos[r]);
      chk("aw_ready_idle", s_awready, 0);
      repeat ($urandom_range(0, 2)) begin
         @(posedge aclk); #1;
         chk("aw_hold", m_awvalid, 1);
      end
      m_awready = 1'b1;
      #1;
      chk("aw_ready_route", s_awready, onehot(r));
      @(posedge aclk);
      exp_q.push_back(RW'(r));
      m_last = r;
      #1;
      m_awready    = 1'b0;
      req_valid[r] = 1'b0;
      apply_aw();
      beats = 0;
      cyc   = 0;
      while (beats <= int'(req_len[r]) && cyc < 200) begin
         d    = {$urandom, $urandom};
         st   = SW'($urandom);
         last = (beats == int'(req_len[r]));
         drive_w(r, d, st, last);
         m_wready = (wmode == 1) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1));
         #1;
         if (beats == abort_beat) return;
         chk("w_valid", m_wvalid, 1);
         chk("w_data", m_wdata, d);
         chk("w_strb", m_wstrb, st);
         chk("w_last", m_wlast, last);
         chk("w_ready_route", s_wready, m_wready ? onehot(r) : '0);
         @(posedge aclk);
         if (m_wready) beats++;
         #1;
         cyc++;
      end
      chk("w_beats", beats, int'(req_len[r]) + 1);
      clear_w();
      chk("cnt_after_burst", outstanding_cnt, exp_q.size());
   endtask

   // One B response: routed to the model's oldest owner, or dropped if none.
   task automatic send_b(input bit slow);
      int h;
      logic [1:0] resp;
      logic [3:0] id;
      resp     = 2'($urandom);
      id       = 4'($urandom);
      m_bvalid = 1'b1;
      m_bresp  = resp;
      m_bid    = id;
      if (exp_q.size() == 0) begin
         s_bready = '0;
         #1;
         chk("orphan_ready", m_bready, 1);
         chk("orphan_pulse", orphan_b, 1);
         chk("orphan_no_route", s_bvalid, 0);
         @(posedge aclk); #1;
         m_bvalid = 1'b0;
         #1;
         chk("orphan_end", orphan_b, 0);
         chk("orphan_cnt", outstanding_cnt, 0);
         return;
      end
      h = int'(exp_q[0]);
      if (slow) begin
         s_bready = ~onehot(h);
         #1;
         chk("b_route_wait", s_bvalid, onehot(h));
         chk("b_hold", m_bready, 0);
         @(posedge aclk); #1;
      end
      s_bready = onehot(h) | NR'($urandom);
      #1;
      chk("b_route", s_bvalid, onehot(h));
      chk("b_ready", m_bready, 1);
      chk("b_resp", s_bresp, resp);
      chk("b_id", s_bid, id);
      chk("b_no_orphan", orphan_b, 0);
      @(posedge aclk);
      void'(exp_q.pop_front());
      #1;
      m_bvalid = 1'b0;
      s_bready = '0;
      #1;
      chk("b_cnt", outstanding_cnt, exp_q.size());
   endtask

   initial begin
      logic [NR-1:0] mask;
      int            r;
      int            first;
      bit            blocked;

      for (int i = 0; i < NR; i++) begin
         req_addr[i] = '0;
         req_id[i]   = '0;
         req_len[i]  = '0;
         req_qos[i]  = '0;
      end

      // Reset with inputs active: every handshake output must stay low.
      #2;
      areset    = 1'b1;
      m_bvalid  = 1'b1;
      s_awvalid = '1;
      s_wvalid  = '1;
      #1;
      check_quiet("reset");
      repeat (2) @(posedge aclk);
      #1;
      m_bvalid  = 1'b0;
      s_awvalid = '0;
      s_wvalid  = '0;
      areset    = 1'b0;

      // Simultaneous requests after reset: req0 first, req1 after its wlast.
      req_addr[0] = 32'h1000_0000; req_id[0] = 4'h3; req_len[0] = 8'd1;
      req_addr[1] = 32'h2000_0040; req_id[1] = 4'hA; req_len[1] = 8'd2;
      req_valid   = 2'b11;
      apply_aw();
      serve(0, 1, 0, -1);
      serve(1, 0, 0, -1);
      while (exp_q.size() > 0) send_b(1);

      // Response with nothing outstanding.
      send_b(0);

      // Four beats from req1 under a toggling m_wready.
      req_addr[1] = 32'h3000_0100; req_len[1] = 8'd3;
      req_valid   = 2'b10;
      apply_aw();
      serve(1, 1, 1, -1);
      chk("fifo_holds_one", outstanding_cnt, 1);
      send_b(0);

      // Fill all outstanding slots; the next request waits for a B.
      for (int k = 0; k < DEPTH; k++) begin
         req_addr[0]  = 32'h4000_0000 + 32'(k * 64);
         req_len[0]   = 8'd0;
         req_valid[0] = 1'b1;
         apply_aw();
         serve(0, 1, 0, -1);
      end
      chk("cnt_full", outstanding_cnt, DEPTH);
      req_addr[1] = 32'h5000_0000; req_len[1] = 8'd0;
      req_valid   = 2'b10;
      apply_aw();
      blocked = 1'b1;
      repeat (6) begin
         @(posedge aclk); #1;
         if (m_awvalid !== 1'b0) blocked = 1'b0;
      end
      chk("full_blocks_grant", blocked, 1);
      send_b(0);
      serve(1, 0, 0, -1);
      chk("cnt_refill", outstanding_cnt, DEPTH);
      while (exp_q.size() > 0) send_b(1'($urandom_range(0, 1)));

      // Randomized rounds of concurrent requests.
      for (int round = 0; round < 12; round++) begin
         mask = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) begin
            req_addr[i] = ($urandom & 32'hFFFF_FFF0) | 32'(i);
            req_id[i]   = 4'($urandom);
            req_len[i]  = 8'($urandom_range(0, 3));
            req_qos[i]  = 4'($urandom);
         end
         req_valid = mask;
         apply_aw();
         while (mask != '0) begin
            r = model_pick(mask);
            serve(r, 0, 0, -1);
            mask[r] = 1'b0;
         end
         while (exp_q.size() > $urandom_range(0, 3)) send_b(1'($urandom_range(0, 1)));
      end
      while (exp_q.size() > 0) send_b(1'($urandom_range(0, 1)));

      // Reset during the second beat of a four-beat burst.
      req_addr[1] = 32'h6000_0000; req_len[1] = 8'd3; req_qos[1] = 4'd0;
      req_valid   = 2'b10;
      apply_aw();
      serve(1, 0, 0, 1);
      areset   = 1'b1;
      m_bvalid = 1'b1;
      s_bready = '1;
      #1;
      check_quiet("mid_burst_reset");
      exp_q.delete();
      m_last = NR - 1;
      repeat (2) @(posedge aclk);
      #1;
      clear_w();
      m_bvalid  = 1'b0;
      s_bready  = '0;
      req_valid = '0;
      apply_aw();
      areset = 1'b0;
      #1;
      check_quiet("after_reset");
      send_b(0);

      // QoS contest: req0 qos=2 vs req1 qos=9.
`ifdef AXI4_WR_ARB_QOS_EN
      first = 1;
`else
      first = 0;
`endif
      req_addr[0] = 32'h7000_0000; req_len[0] = 8'd0; req_qos[0] = 4'd2;
      req_addr[1] = 32'h7100_0000; req_len[1] = 8'd0; req_qos[1] = 4'd9;
      req_valid   = 2'b11;
      apply_aw();
      serve(first, 1, 0, -1);
      serve(1 - first, 0, 0, -1);
      while (exp_q.size() > 0) send_b(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi4_write_arbiter.md
AXI4_WRITE_ARBITER -- requirements
Module: axi4_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of upstream write requesters (2..4).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32: awaddr width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: wdata width; wstrb is DATA_WIDTH/8.
REQ-004 SHALL have parameter OUTSTANDING_DEPTH, default 16: maximum granted bursts awaiting B.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 aclk  in  1  clock; all logic on rising edge.
REQ-007 areset  in  1  asynchronous active-high reset.
REQ-008 s_awvalid / s_awready  in / out  NUM_REQ each  per-requester AW handshake.
REQ-009 s_awaddr, s_awid, s_awlen, s_awqos  in  NUM_REQ x (ADDRESS_WIDTH, 4, 8, 4)  packed per-requester AW payload.
REQ-010 s_wvalid, s_wlast / s_wready  in / out  NUM_REQ each  per-requester W handshake.
REQ-011 s_wdata, s_wstrb  in  NUM_REQ x (DATA_WIDTH, DATA_WIDTH/8)  per-requester W payload.
REQ-012 s_bvalid / s_bready  out / in  NUM_REQ each  per-requester B handshake; s_bresp out 2, s_bid out 4 are shared.
REQ-013 m_awvalid out 1, m_awready in 1, m_awaddr/m_awid/m_awlen/m_awqos out: single downstream AW.
REQ-014 m_wvalid, m_wlast, m_wdata, m_wstrb out; m_wready in 1: downstream W.
REQ-015 m_bvalid in 1, m_bready out 1, m_bresp in 2, m_bid in 4: downstream B.
REQ-016 outstanding_cnt  out  $clog2(OUTSTANDING_DEPTH+1)  granted bursts without B.
REQ-017 orphan_b  out  1  one-cycle pulse when m_bvalid arrives with no outstanding burst.

Function
REQ-018 FSM SHALL have states IDLE, AW_PHASE, W_PHASE.
REQ-019 IDLE: if any s_awvalid and outstanding_cnt < OUTSTANDING_DEPTH, SHALL register winner and go to AW_PHASE next cycle; otherwise stay.
REQ-020 Arbitration SHALL be round-robin starting from the index after the last winner (index 0 after reset).
REQ-021 AW_PHASE: m_aw* SHALL mirror the winner's AW; s_awready[winner] = m_awready; the cycle m_awvalid && m_awready goes to W_PHASE.
REQ-022 W_PHASE: m_w* SHALL mirror the winner's W; s_wready[winner] = m_wready; all other s_wready = 0; the handshake with m_wlast=1 returns to IDLE.
REQ-023 Grant-to-m_awvalid latency SHALL be exactly 1 cycle; W passthrough SHALL be combinational (zero latency).
REQ-024 Requester index SHALL be pushed into a route FIFO on each AW handshake and popped on each B handshake.
REQ-025 m_bvalid SHALL route to s_bvalid[FIFO head]; m_bready = s_bready[head]; s_bresp/s_bid carry m_bresp/m_bid unchanged.
REQ-026 Simultaneous push and pop SHALL leave outstanding_cnt unchanged.
REQ-027 FIFO full (cnt = OUTSTANDING_DEPTH) SHALL block new grants only; an AW_PHASE/W_PHASE already in progress completes.
REQ-028 FIFO empty with m_bvalid=1 SHALL drive m_bready=1 (drop the response), pulse orphan_b, and leave cnt at 0.
REQ-029 A requester dropping s_awvalid before grant SHALL simply not be granted; after grant the arbiter does not re-check it.

Reset
REQ-030 Reset SHALL force IDLE, cnt=0, FIFO empty, last winner=NUM_REQ-1, and all valid/ready outputs plus orphan_b to 0.
REQ-031 Reset mid-burst SHALL abandon the burst and discard all routing state; no B is routed after reset.

Configuration
REQ-032 With AXI4_WR_ARB_QOS_EN defined, the highest s_awqos among valid requesters SHALL win, with round-robin among ties.
REQ-033 Without AXI4_WR_ARB_QOS_EN, s_awqos SHALL be ignored for arbitration (still forwarded) and pure round-robin SHALL apply.

Structure
REQ-034 The arb_state_e enum (IDLE/AW_PHASE/W_PHASE) and the OUTSTANDING_DEPTH default SHALL be defined in axi4_globals_pkg, the shared AXI4 package.
REQ-035 The route FIFO SHALL be a sub-module, axi4_route_fifo (depth and width parameters, push/pop/full/empty/count).

Verification
REQ-036 Req0 and req1 assert awvalid in the same cycle after reset -> req0 granted first; req1 granted after req0 wlast; m_awaddr matches each in turn.
REQ-037 Req1 sends awlen=3 with m_wready toggling every cycle -> exactly 4 W beats forwarded, last with m_wlast=1, FIFO holds {1}.
REQ-038 16 single-beat bursts with m_bvalid held low -> cnt=16, 17th s_awvalid not granted until one B handshake, then granted.
REQ-039 m_bvalid with an empty FIFO -> m_bready=1, orphan_b high for 1 cycle, cnt stays 0.
REQ-040 areset asserted in W_PHASE beat 2 of 4 -> all outputs 0 in the same cycle, IDLE, cnt=0.
REQ-041 With AXI4_WR_ARB_QOS_EN: req0 qos=2, req1 qos=9 simultaneously -> req1 granted first; without the macro -> req0 first.
